// File: rtl/a5_pkg.sv
// Shared types and constants for the A5/1 keystream packing path.
package a5_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } packer_state_t;

   localparam int A5_WORD_W         = 32;
   localparam int A5_GSM_FRAME_BITS = 228;
   localparam int A5_BURST_BITS     = 114;

endpackage

// File: rtl/a5_keystream_packer_if.sv
// Word stream from the packer FIFO to the bus-side reader.
interface a5_keystream_packer_if
   import a5_pkg::*;
#(
   parameter int WORD_W = A5_WORD_W
) ();

   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;
   logic              out_last;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/a5_word_fifo.sv
// First-word fall-through FIFO holding {last, data} entries; push and pop may coincide at any level.
module a5_word_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic [DATA_W-1:0]      push_data,
   input  logic                   push_last,
   input  logic                   pop,
   output logic [DATA_W-1:0]      head_data,
   output logic                   head_last,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W:0]    mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is datapath only; pointers and count carry all control state.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {push_last, push_data};
   end

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // Empty head reads as zero so the bus sees clean values after reset.
   assign {head_last, head_data} = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/a5_keystream_packer.sv
// Gates the A5/1 generator clock, packs keystream bits MSB-first into words and queues them for the reader.
module a5_keystream_packer
   import a5_pkg::*;
#(
   parameter int FRAME_BITS = A5_GSM_FRAME_BITS,
   parameter int FIFO_DEPTH = 4,
   parameter int WORD_W     = A5_WORD_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   output logic                  lfsr_clk_en,
   input  logic                  d,
   a5_keystream_packer_if.master out_bus,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam int IDX_W = $clog2(WORD_W);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   packer_state_t     state;
   packer_state_t     state_nxt;
   logic [CNT_W-1:0]  bits_left;
   logic [CNT_W-1:0]  bits_left_nxt;
   logic [IDX_W-1:0]  bit_idx;
   logic [IDX_W-1:0]  bit_idx_nxt;
   logic [WORD_W-2:0] shreg;
   logic [WORD_W-2:0] shreg_nxt;
   logic [WORD_W-1:0] word_raw;
   logic [WORD_W-1:0] push_word;
   logic              push;
   logic              push_last;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LVL_W-1:0]  fifo_count;
   logic [WORD_W-1:0] head_data;
   logic              head_last;

   a5_word_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (WORD_W)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_word),
      .push_last (push_last),
      .pop       (pop),
      .head_data (head_data),
      .head_last (head_last),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_bus.out_valid = !fifo_empty;
   assign out_bus.out_data  = head_data;
   assign out_bus.out_last  = head_last;
   assign pop               = !fifo_empty && out_bus.out_ready;
   assign busy              = (state != IDLE);
   assign word_raw          = {shreg, d};

   always_comb begin
      state_nxt     = state;
      bits_left_nxt = bits_left;
      bit_idx_nxt   = bit_idx;
      shreg_nxt     = shreg;
      lfsr_clk_en   = 1'b0;
      push          = 1'b0;
      push_last     = 1'b0;
      push_word     = word_raw;
      done          = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               bits_left_nxt = CNT_W'(FRAME_BITS);
               bit_idx_nxt   = '0;
               shreg_nxt     = '0;
               state_nxt     = RUN;
            end
         end
         RUN: begin
            // Enable looks only at the registered level, so a pop this cycle does not unblock it.
            lfsr_clk_en = !fifo_full;
            if (lfsr_clk_en) begin
               shreg_nxt     = word_raw[WORD_W-2:0];
               bits_left_nxt = bits_left - CNT_W'(1);
               if (bits_left == CNT_W'(1)) begin
                  push      = 1'b1;
                  push_last = 1'b1;
                  push_word = word_raw << (IDX_W'(WORD_W - 1) - bit_idx);
                  state_nxt = DRAIN;
               end else if (bit_idx == IDX_W'(WORD_W - 1)) begin
                  push        = 1'b1;
                  bit_idx_nxt = '0;
               end else begin
                  bit_idx_nxt = bit_idx + IDX_W'(1);
               end
            end
         end
         DRAIN: begin
            // The last-tagged word is always the final entry left in the FIFO.
            if (pop && head_last && fifo_count == LVL_W'(1)) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         bits_left <= '0;
         bit_idx   <= '0;
      end else begin
         state     <= state_nxt;
         bits_left <= bits_left_nxt;
         bit_idx   <= bit_idx_nxt;
      end
   end

   always_ff @(posedge clk) begin
      shreg <= shreg_nxt;
   end

endmodule

// File: doc/a5_keystream_packer.md
Name: a5_keystream_packer

Overview:
Downstream consumer of the A5/1 keystream generator. Drives the generator's LFSR clock enable, captures one keystream bit `d` per enabled cycle, and packs bits MSB-first into 32-bit words. Words go into a small FIFO for the bus-side reader. One frame is FRAME_BITS bits (GSM default 228 = 2 x 114-bit bursts); the final word is flagged and zero-padded.

Parameters:
- FRAME_BITS, 228, keystream bits per frame (1..4095).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).
- WORD_W, 32, packed word width.

Ports:
- clk  in  1  system clock; the generator is on the same clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a frame; ignored unless IDLE.
- lfsr_clk_en  out  1  clock enable to the generator.
- d  in  1  keystream bit; combinational from the generator's current state.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  reader accepts head.
- out_data  out  WORD_W  packed keystream word.
- out_last  out  1  head word is the frame's final word.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the last word is popped.

Behaviour:
- Reset values:
  - lfsr_clk_en=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
  - FIFO empty, counters 0, state IDLE.
- States:
  - IDLE: on start=1, load bits_left=FRAME_BITS, bit_idx=0, word shift register=0, go to RUN.
  - RUN: lfsr_clk_en = !fifo_full (combinational from registered FIFO count).
  - RUN, each cycle with lfsr_clk_en=1:
    - Sample d before the generator shifts (same edge).
    - shreg <= {shreg[WORD_W-2:0], d}; bit_idx++; bits_left--.
  - Word completion: when bit_idx==WORD_W-1 or bits_left==1, the completed word {shreg,d} is written to the FIFO in the same edge.
  - Final word: if bits_left==1, the word is left-aligned with zeros in the LSBs (shift by WORD_W-1-bit_idx), tagged last=1, and state goes to DRAIN. Otherwise bit_idx wraps to 0.
  - Push never fails: the enable already requires !full.
  - DRAIN: lfsr_clk_en=0; wait for the FIFO to empty.
  - On the pop of the last-tagged word, done=1 for that cycle; state goes to IDLE on the same edge.
- FIFO:
  - First-word fall-through; pop = out_valid & out_ready.
  - Simultaneous push and pop is legal at any occupancy, including full (count unchanged).
- Exact-multiple frames: FRAME_BITS % WORD_W == 0 gives no padding and no extra word.
- Word count per frame = ceil(FRAME_BITS/WORD_W).
- A start pulse in RUN or DRAIN is ignored, with no effect on counters.
- Reset mid-frame: everything returns to reset values asynchronously and the FIFO contents are discarded. The generator is reset by the same reset_n.
- lfsr_clk_en never asserts outside RUN.
- Total enabled cycles per frame = FRAME_BITS exactly.

Decomposition:
- Package a5_pkg:
  - packer_state_t enum (IDLE, RUN, DRAIN).
  - A5_WORD_W=32.
  - A5_GSM_FRAME_BITS=228.
  - A5_BURST_BITS=114.
- Submodule a5_word_fifo:
  - Parameterised depth and width.
  - Entry holds {last, data}.
  - Exposes full, empty, count.
- Packing FSM and counters live in the top.

Test Plan:
- d held 1, out_ready=1, FRAME_BITS=228, start pulse:
  - 7 words 0xFFFFFFFF, then 0xF0000000 with out_last=1.
  - done pulses once; lfsr_clk_en high for exactly 228 cycles.
- d alternating 1,0,1,0 from the first enabled cycle:
  - Every full word is 0xAAAAAAAA.
  - Last word is 0xA0000000.
- out_ready=0 throughout:
  - After 128 enabled cycles, FIFO full (4 words) and lfsr_clk_en drops.
  - Raise out_ready for one cycle: exactly one pop, and enable resumes.
  - No bit lost or duplicated (check against the bit sequence).
- FRAME_BITS=64, d=1:
  - Exactly 2 words 0xFFFFFFFF; second has out_last=1; no padded third word.
- start pulses in RUN and in DRAIN:
  - Ignored; word count and contents identical to the single-start run.
  - A start in IDLE after done begins a fresh frame.
- reset_n asserted at bit 100, asynchronously mid-cycle:
  - All outputs at reset values immediately; out_valid=0 after release.
  - A new start produces a complete, correct 228-bit frame.
